// File: rtl/addsub_chunked_if.sv
// addsub_chunked_if: request/result bundle for the chunked adder/subtractor.
//   start    : request strobe, honoured only while the unit is idle or done
//   sub      : 0 = a + b, 1 = a - b
//   a, b     : operands, sampled with an accepted start
//   busy     : high while an operation is being processed
//   done     : one-cycle pulse when new results are valid
//   sum      : result modulo 2^WIDTH
//   carry    : carry out of the MSB (subtract: 1 = no borrow)
//   overflow : two's-complement overflow
//   zero     : sum == 0
interface addsub_chunked_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;
  logic             zero;

  // Requester side.
  modport master (
    output start, sub, a, b,
    input  busy, done, sum, carry, overflow, zero
  );

  // Arithmetic unit side.
  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, carry, overflow, zero
  );
endinterface

// File: rtl/addsub_chunked.sv
// addsub_chunked: multi-cycle adder/subtractor processing CHUNK bits per clock.
//   i_clk   : clock, all state changes on the rising edge
//   i_reset : synchronous active-high reset, aborts any operation in flight
//   bus     : addsub_chunked_if slave (start/sub/a/b in, busy/done/sum/flags out)
// An accepted request takes N = WIDTH/CHUNK RUN cycles; results and the done
// pulse appear N cycles after the accepting edge. Result registers only change
// on the RUN->DONE transition, so they stay stable for downstream logic.
module addsub_chunked #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  addsub_chunked_if.slave  bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((WIDTH < 2) || (CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $error("addsub_chunked: illegal WIDTH/CHUNK combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;        // A, shifted right one chunk per RUN cycle
  logic [WIDTH-1:0] b_r;        // B' = B ^ {WIDTH{sub}}, shifted likewise
  logic [WIDTH-1:0] part_r;     // partial sum, filled from the top down
  logic             carry_r;    // inter-chunk carry, seeded with sub
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             res_carry_r;
  logic             ovf_r;
  logic             zero_r;

  logic [CHUNK:0]   chunk_s;    // {carry out, CHUNK-bit sum} of the current chunk
  logic [WIDTH-1:0] part_next_s;
  logic             last_s;
  logic             ovf_s;

  assign chunk_s = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, carry_r};

  // New chunk enters at the top; after N cycles chunk 0 has reached the LSBs.
  assign part_next_s = (part_r >> CHUNK)
                     | (WIDTH'(chunk_s[CHUNK-1:0]) << (WIDTH - CHUNK));

  assign last_s = (cnt_r == CW'(N - 1));

  // On the last chunk the bottom bits of a_r/b_r hold the operand MSBs.
  assign ovf_s = (a_r[CHUNK-1] == b_r[CHUNK-1]) && (chunk_s[CHUNK-1] != a_r[CHUNK-1]);

  // Control FSM, chunk datapath and registered result/flag outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r     <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      part_r      <= '0;
      carry_r     <= 1'b0;
      cnt_r       <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      sum_r       <= '0;
      res_carry_r <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_r     <= bus.a;
            b_r     <= bus.b ^ {WIDTH{bus.sub}};
            carry_r <= bus.sub;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_r     <= a_r >> CHUNK;
          b_r     <= b_r >> CHUNK;
          part_r  <= part_next_s;
          carry_r <= chunk_s[CHUNK];
          cnt_r   <= cnt_r + CW'(1);
          if (last_s) begin
            sum_r       <= part_next_s;
            res_carry_r <= chunk_s[CHUNK];
            ovf_r       <= ovf_s;
            zero_r      <= (part_next_s == '0);
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            state_r     <= DONE;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.sum      = sum_r;
  assign bus.carry    = res_carry_r;
  assign bus.overflow = ovf_r;
  assign bus.zero     = zero_r;

endmodule

// File: tb/tb_addsub_chunked.sv
// tb_addsub_chunked: drives three addsub_chunked instances (CHUNK 4, 1, 16)
// with directed vectors and random operands. Expected results are queued at
// issue time; a single monitor compares busy, done timing, results and result
// hold behaviour every cycle for each instance.
module tb_addsub_chunked;

  localparam int NS [3] = '{4, 16, 1};   // cycles per operation per instance

  typedef struct {
    logic [15:0] sum;
    logic        c;
    logic        o;
    logic        z;
    int          acc;   // cycle index of the accepting edge
    int          dn;    // cycle index after which done must be high
  } exp_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  logic [2:0]  rst_v;
  logic [2:0]  rst_edge;
  logic [2:0]  start_v;
  logic [2:0]  sub_v;
  logic [15:0] a_v [3];
  logic [15:0] b_v [3];
  logic [2:0]  busy_v, done_v, carry_v, ovf_v, zero_v;
  logic [15:0] sum_v [3];

  exp_t        exp_q [3][$];
  logic [15:0] held_sum [3];
  logic [2:0]  held_c, held_o, held_z;
  int          pass_cnt = 0;
  int          chk_cnt  = 0;

  always #5 clk = ~clk;

  addsub_chunked_if #(.WIDTH(16)) bus4 ();
  addsub_chunked_if #(.WIDTH(16)) bus1 ();
  addsub_chunked_if #(.WIDTH(16)) bus16 ();

  addsub_chunked #(.WIDTH(16), .CHUNK(4))  u_c4  (.i_clk(clk), .i_reset(rst_v[0]), .bus(bus4.slave));
  addsub_chunked #(.WIDTH(16), .CHUNK(1))  u_c1  (.i_clk(clk), .i_reset(rst_v[1]), .bus(bus1.slave));
  addsub_chunked #(.WIDTH(16), .CHUNK(16)) u_c16 (.i_clk(clk), .i_reset(rst_v[2]), .bus(bus16.slave));

  assign bus4.start  = start_v[0];
  assign bus4.sub    = sub_v[0];
  assign bus4.a      = a_v[0];
  assign bus4.b      = b_v[0];
  assign bus1.start  = start_v[1];
  assign bus1.sub    = sub_v[1];
  assign bus1.a      = a_v[1];
  assign bus1.b      = b_v[1];
  assign bus16.start = start_v[2];
  assign bus16.sub   = sub_v[2];
  assign bus16.a     = a_v[2];
  assign bus16.b     = b_v[2];

  assign busy_v  = {bus16.busy, bus1.busy, bus4.busy};
  assign done_v  = {bus16.done, bus1.done, bus4.done};
  assign carry_v = {bus16.carry, bus1.carry, bus4.carry};
  assign ovf_v   = {bus16.overflow, bus1.overflow, bus4.overflow};
  assign zero_v  = {bus16.zero, bus1.zero, bus4.zero};
  assign sum_v[0] = bus4.sum;
  assign sum_v[1] = bus1.sum;
  assign sum_v[2] = bus16.sum;

  // Cycle counter and per-instance record of reset at each rising edge.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst_v;
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s dut%0d cyc %0d: got %h want %h", nm, d, cyc, act, req);
  endtask

  // Monitor: pops the scoreboard on the expected done cycle, checks holds otherwise.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int d = 0; d < 3; d++) begin
        if (rst_edge[d]) begin
          chk("reset_outputs", d,
              {11'd0, busy_v[d], done_v[d], carry_v[d], ovf_v[d], zero_v[d], sum_v[d]}, 32'd0);
          held_sum[d] = 16'h0000;
          held_c[d] = 1'b0;
          held_o[d] = 1'b0;
          held_z[d] = 1'b0;
        end else begin
          logic eb;
          eb = (exp_q[d].size() > 0) && (cyc >= exp_q[d][0].acc) && (cyc < exp_q[d][0].dn);
          chk("busy", d, {31'd0, busy_v[d]}, {31'd0, eb});
          if ((exp_q[d].size() > 0) && (cyc == exp_q[d][0].dn)) begin
            chk("done_pulse", d, {31'd0, done_v[d]}, 32'd1);
            chk("sum", d, {16'd0, sum_v[d]}, {16'd0, exp_q[d][0].sum});
            chk("carry", d, {31'd0, carry_v[d]}, {31'd0, exp_q[d][0].c});
            chk("overflow", d, {31'd0, ovf_v[d]}, {31'd0, exp_q[d][0].o});
            chk("zero", d, {31'd0, zero_v[d]}, {31'd0, exp_q[d][0].z});
            held_sum[d] = exp_q[d][0].sum;
            held_c[d] = exp_q[d][0].c;
            held_o[d] = exp_q[d][0].o;
            held_z[d] = exp_q[d][0].z;
            void'(exp_q[d].pop_front());
          end else begin
            chk("no_done", d, {31'd0, done_v[d]}, 32'd0);
            chk("hold_result", d,
                {13'd0, carry_v[d], ovf_v[d], zero_v[d], sum_v[d]},
                {13'd0, held_c[d], held_o[d], held_z[d], held_sum[d]});
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int d, input logic sub, input logic [15:0] a, input logic [15:0] b);
    start_v[d] = 1'b1;
    sub_v[d]   = sub;
    a_v[d]     = a;
    b_v[d]     = b;
  endtask

  task automatic push_exp(input int d, input logic [15:0] es, input logic ec, input logic eo,
                          input logic ez, input int acc);
    exp_t e;
    e.sum = es;
    e.c   = ec;
    e.o   = eo;
    e.z   = ez;
    e.acc = acc;
    e.dn  = acc + NS[d];
    exp_q[d].push_back(e);
  endtask

  // Same directed vector on all three instances, then wait out the slowest.
  task automatic run_vec(input logic sub, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] es, input logic ec, input logic eo, input logic ez);
    for (int d = 0; d < 3; d++) begin
      drive(d, sub, a, b);
      push_exp(d, es, ec, eo, ez, cyc + 1);
    end
    tick();
    start_v = 3'b000;
    repeat (18) tick();
  endtask

  // Independent reference: unsigned compare for borrow, signed range for overflow.
  function automatic exp_t model(input logic sub, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [16:0] u;
    int          r;
    u = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    r = sub ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
    e.sum = u[15:0];
    e.c   = sub ? (a >= b) : u[16];
    e.o   = (r > 32767) || (r < -32768);
    e.z   = (u[15:0] == 16'h0000);
    e.acc = 0;
    e.dn  = 0;
    return e;
  endfunction

  initial begin
    int k;
    rst_v   = 3'b111;
    start_v = 3'b000;
    sub_v   = 3'b000;
    for (int d = 0; d < 3; d++) begin
      a_v[d] = 16'h0000;
      b_v[d] = 16'h0000;
    end
    repeat (3) tick();
    rst_v = 3'b000;
    tick();

    // Directed arithmetic: sub, a, b, sum, carry, overflow, zero.
    run_vec(1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0);
    run_vec(1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_vec(1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_vec(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_vec(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_vec(1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_vec(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_vec(1'b1, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_vec(1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1);
    run_vec(1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0);

    // Start pulse with new operands during RUN is ignored (CHUNK 4).
    drive(0, 1'b0, 16'h1111, 16'h2222);
    push_exp(0, 16'h3333, 1'b0, 1'b0, 1'b0, cyc + 1);
    tick();
    start_v[0] = 1'b0;
    tick();
    drive(0, 1'b1, 16'hFFFF, 16'h0001);
    tick();
    start_v[0] = 1'b0;
    repeat (10) tick();

    // Start held high through DONE: second op accepted with no IDLE cycle.
    k = cyc + 1;
    drive(0, 1'b0, 16'h1234, 16'h4321);
    push_exp(0, 16'h5555, 1'b0, 1'b0, 1'b0, k);
    tick();
    drive(0, 1'b1, 16'h0003, 16'h0005);
    push_exp(0, 16'hFFFE, 1'b0, 1'b0, 1'b0, k + NS[0] + 1);
    repeat (5) tick();
    start_v[0] = 1'b0;
    repeat (10) tick();

    // Reset during the second RUN cycle aborts without a done pulse.
    drive(0, 1'b0, 16'h7FFF, 16'h0001);
    push_exp(0, 16'h8000, 1'b0, 1'b1, 1'b0, cyc + 1);
    tick();
    start_v[0] = 1'b0;
    tick();
    rst_v[0] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    exp_q[0].delete();
    repeat (2) tick();
    drive(0, 1'b0, 16'h1234, 16'h4321);
    push_exp(0, 16'h5555, 1'b0, 1'b0, 1'b0, cyc + 1);
    tick();
    start_v[0] = 1'b0;
    repeat (8) tick();

    // Random operand/mode sets on all three instances.
    for (int i = 0; i < 1000; i++) begin
      logic        rs;
      logic [15:0] ra, rb;
      exp_t        e;
      rs = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      rb = 16'($urandom);
      e  = model(rs, ra, rb);
      for (int d = 0; d < 3; d++) begin
        drive(d, rs, ra, rb);
        push_exp(d, e.sum, e.c, e.o, e.z, cyc + 1);
      end
      tick();
      start_v = 3'b000;
      repeat (17) tick();
    end

    repeat (3) tick();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
